// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: return-path end of the coin interface. Latches a balance on request and
// drives a hopper one coin per valid/ready handshake, largest denomination first. Any remainder
// that cannot be paid out is reported with a one-cycle done pulse.
// Optional feature: define COIN_INVENTORY_EN to track a per-coin stock and skip empty tubes.

`ifndef kNumCoins
`define kNumCoins 3
`endif

module coin_change_dispenser #(
    parameter int unsigned TOTAL_W    = 32,
    parameter int unsigned COIN0_VAL  = 100,
    parameter int unsigned COIN1_VAL  = 500,
    parameter int unsigned COIN2_VAL  = 1000,
    parameter int unsigned STOCK_W    = 8,
    parameter int unsigned STOCK_INIT = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [TOTAL_W-1:0]    i_amount,
    input  logic                  i_coin_ready,
    output logic [`kNumCoins-1:0] o_coin,
    output logic                  o_coin_valid,
    output logic                  o_busy,
    output logic [TOTAL_W-1:0]    o_remaining,
    output logic                  o_done,
    output logic [TOTAL_W-1:0]    o_residue,
    input  logic [`kNumCoins-1:0] i_stock_add,
    output logic                  o_shortfall
);

    localparam int unsigned NumCoins = `kNumCoins;
    localparam logic [TOTAL_W-1:0] Coin0Val = TOTAL_W'(COIN0_VAL);
    localparam logic [TOTAL_W-1:0] Coin1Val = TOTAL_W'(COIN1_VAL);
    localparam logic [TOTAL_W-1:0] Coin2Val = TOTAL_W'(COIN2_VAL);

    typedef enum logic [1:0] {StIdle, StSel, StDisp, StDone} state_e;

    state_e              state_q, state_d;
    logic [TOTAL_W-1:0]  rem_q, rem_d;
    logic [TOTAL_W-1:0]  residue_q, residue_d;
    logic [NumCoins-1:0] coin_q, coin_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                short_q, short_d;

    logic [NumCoins-1:0] fits;
    logic [NumCoins-1:0] stock_ok;
    logic [NumCoins-1:0] avail;
    logic [TOTAL_W-1:0]  coin_val;
    logic                handshake;

    assign handshake = (state_q == StDisp) && valid_q && i_coin_ready;
    // A coin may only be chosen when it fits the balance, so rem can never underflow.
    assign fits      = {Coin2Val <= rem_q, Coin1Val <= rem_q, Coin0Val <= rem_q};
    assign avail     = fits & stock_ok;

    // Value of the coin currently presented to the hopper.
    always_comb begin
        coin_val = '0;
        if (coin_q[2]) begin
            coin_val = Coin2Val;
        end else if (coin_q[1]) begin
            coin_val = Coin1Val;
        end else if (coin_q[0]) begin
            coin_val = Coin0Val;
        end
    end

`ifdef COIN_INVENTORY_EN
    localparam logic [STOCK_W-1:0] StockInit = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q [NumCoins];
    logic [STOCK_W-1:0] stock_d [NumCoins];

    // Stock bookkeeping: refill saturates, a refill and a payout of the same coin cancel.
    always_comb begin
        for (int i = 0; i < NumCoins; i++) begin
            stock_d[i]  = stock_q[i];
            stock_ok[i] = (stock_q[i] != '0);
            if (i_stock_add[i] && !(handshake && coin_q[i])) begin
                if (stock_q[i] != '1) begin
                    stock_d[i] = stock_q[i] + 1'b1;
                end
            end else if (!i_stock_add[i] && handshake && coin_q[i]) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
        end
    end

    // Stock registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumCoins; i++) begin
                stock_q[i] <= StockInit;
            end
        end else begin
            for (int i = 0; i < NumCoins; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign o_shortfall = short_q;
`else
    logic unused_stock_add;
    logic unused_short;

    // Unlimited stock: every denomination is always available.
    assign stock_ok         = '1;
    assign unused_stock_add = ^i_stock_add;
    assign unused_short     = short_q;
    assign o_shortfall      = 1'b0;
`endif

    // Next-state and registered-output logic of the dispense FSM.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        residue_d = residue_q;
        coin_d    = coin_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        short_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    rem_d   = i_amount;
                    busy_d  = 1'b1;
                    state_d = StSel;
                end
            end
            StSel: begin
                if (avail[2]) begin
                    coin_d  = 3'b100;
                    valid_d = 1'b1;
                    state_d = StDisp;
                end else if (avail[1]) begin
                    coin_d  = 3'b010;
                    valid_d = 1'b1;
                    state_d = StDisp;
                end else if (avail[0]) begin
                    coin_d  = 3'b001;
                    valid_d = 1'b1;
                    state_d = StDisp;
                end else begin
                    residue_d = rem_q;
                    done_d    = 1'b1;
                    // Still >= smallest coin here means stock ran out, not a true residue.
                    short_d   = fits[0];
                    state_d   = StDone;
                end
            end
            StDisp: begin
                // Coin and valid hold until the hopper takes the coin.
                if (handshake) begin
                    rem_d   = rem_q - coin_val;
                    coin_d  = '0;
                    valid_d = 1'b0;
                    state_d = StSel;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            residue_q <= '0;
            coin_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            residue_q <= residue_d;
            coin_q    <= coin_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            short_q   <= short_d;
        end
    end

    assign o_coin       = coin_q;
    assign o_coin_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_remaining  = rem_q;
    assign o_done       = done_q;
    assign o_residue    = residue_q;

endmodule
